board_state: RTL and testbench

//  Authoritative 8x8 chess board store; directly upstream of the VGA board renderer.

---
 rtl/chess_pkg.sv | 58 +++++
 rtl/vblank_sync.sv | 32 +++
 rtl/board_state.sv | 115 +++++++++++
 tb/tb_board_state.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess definitions for the board store and the VGA board renderer.
//  piece_t     : 5-bit square code {colour, type, has_moved}
//  EMPTY..KING : piece type codes
//  board_t     : 64 squares, index = row*8 + col, row 0 = top of screen
//  START_POS   : standard opening position, nothing moved
//  bs_state_t  : board_state move-sequencer states
package chess_pkg;

  typedef struct packed {
    logic       colour;   // 0 white, 1 black
    logic [2:0] ptype;
    logic       moved;
  } piece_t;

  localparam logic [2:0] EMPTY  = 3'd0;
  localparam logic [2:0] PAWN   = 3'd1;
  localparam logic [2:0] KNIGHT = 3'd2;
  localparam logic [2:0] BISHOP = 3'd3;
  localparam logic [2:0] ROOK   = 3'd4;
  localparam logic [2:0] QUEEN  = 3'd5;
  localparam logic [2:0] KING   = 3'd6;

  typedef logic [5:0]   sq_idx_t;
  typedef piece_t [63:0] board_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ERR,
    ST_WAITVB,
    ST_COMMIT
  } bs_state_t;

  function automatic logic [2:0] back_rank(input logic [2:0] col);
    case (col)
      3'd0, 3'd7: back_rank = ROOK;
      3'd1, 3'd6: back_rank = KNIGHT;
      3'd2, 3'd5: back_rank = BISHOP;
      3'd3:       back_rank = QUEEN;
      default:    back_rank = KING;
    endcase
  endfunction

  function automatic board_t start_position();
    board_t b;
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[c]      = piece_t'{colour: 1'b1, ptype: back_rank(c[2:0]), moved: 1'b0};
      b[8 + c]  = piece_t'{colour: 1'b1, ptype: PAWN,              moved: 1'b0};
      b[48 + c] = piece_t'{colour: 1'b0, ptype: PAWN,              moved: 1'b0};
      b[56 + c] = piece_t'{colour: 1'b0, ptype: back_rank(c[2:0]), moved: 1'b0};
    end
    return b;
  endfunction

  localparam board_t START_POS = start_position();

endpackage

// File: rtl/vblank_sync.sv
// Brings the VGA vsync (active low, vgaclk domain) into clk and flags the
// start of vertical blanking.
//  clk          in  system clock
//  reset        in  async, active-high; flops preset to 1 (vsync idle level)
//  vsync        in  active-low vsync
//  vblank_start out 1-cycle pulse on a synchronized falling edge of vsync
module vblank_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync,
  output logic vblank_start
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], vsync};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Both terms are flops, so the pulse is glitch-free.
  assign vblank_start = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/board_state.sv
// Authoritative 8x8 board store feeding the VGA renderer. Takes one move at
// a time over valid/ready and commits it at the start of vblank so a frame
// never shows a half-applied move.
//  clk, reset           clock, async active-high reset (loads start position)
//  new_game             sync pulse: reload start position, drop pending move
//  vsync                active-low vsync from vgaController
//  move_valid/ready     move handshake
//  move_from, move_to   square indices, row*8+col
//  move_done, move_err  1-cycle result pulses
//  captured             previous code of move_to, valid with move_done
//  board_flat           all squares, square idx at [idx*5 +: 5]
module board_state
  import chess_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit WAIT_VBLANK = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         new_game,
  input  logic         vsync,
  input  logic         move_valid,
  output logic         move_ready,
  input  logic [5:0]   move_from,
  input  logic [5:0]   move_to,
  output logic         move_done,
  output logic         move_err,
  output logic [4:0]   captured,
  output logic [319:0] board_flat
);

  board_t    board;
  bs_state_t state;
  sq_idx_t   from_q, to_q;
  piece_t    piece_q;
  piece_t    placed;
  logic      bad_move;
  logic      vblank_start;

  vblank_sync #(.SYNC_STAGES(SYNC_STAGES)) u_vblank_sync (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .vblank_start (vblank_start)
  );

  assign move_ready = (state == ST_IDLE) & ~new_game;
  assign board_flat = board;

  assign bad_move = (piece_q.ptype == EMPTY) | (from_q == to_q);

  // Piece as it lands: marked moved, pawns reaching the far rank become queens.
  always_comb begin
    placed       = piece_q;
    placed.moved = 1'b1;
    if (piece_q.ptype == PAWN &&
        ((!piece_q.colour && to_q[5:3] == 3'd0) ||
         ( piece_q.colour && to_q[5:3] == 3'd7)))
      placed.ptype = QUEEN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      board     <= START_POS;
      state     <= ST_IDLE;
      move_done <= 1'b0;
      move_err  <= 1'b0;
      captured  <= '0;
      from_q    <= '0;
      to_q      <= '0;
      piece_q   <= '0;
    end else begin
      move_done <= 1'b0;
      move_err  <= 1'b0;
      if (new_game) begin
        // Wins over everything, including a commit on this same edge.
        board <= START_POS;
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (move_valid) begin
              from_q  <= move_from;
              to_q    <= move_to;
              piece_q <= board[move_from];
              state   <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (bad_move)         state <= ST_ERR;
            else if (WAIT_VBLANK) state <= ST_WAITVB;
            else                  state <= ST_COMMIT;
          end
          ST_ERR: begin
            move_err <= 1'b1;
            state    <= ST_IDLE;
          end
          ST_WAITVB: begin
            // Only edges seen here count; earlier ones belong to the old frame.
            if (vblank_start) state <= ST_COMMIT;
          end
          ST_COMMIT: begin
            board[to_q]   <= placed;
            board[from_q] <= '0;
            captured      <= board[to_q];
            move_done     <= 1'b1;
            state         <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state (WAIT_VBLANK=1, SYNC_STAGES=2).
module tb_board_state;

  localparam int SS = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         new_game = 1'b0;
  logic         vsync = 1'b1;
  logic         move_valid = 1'b0;
  logic         move_ready;
  logic [5:0]   move_from = '0;
  logic [5:0]   move_to = '0;
  logic         move_done;
  logic         move_err;
  logic [4:0]   captured;
  logic [319:0] board_flat;

  always #10 clk = ~clk;

  board_state #(.SYNC_STAGES(SS), .WAIT_VBLANK(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .vsync      (vsync),
    .move_valid (move_valid),
    .move_ready (move_ready),
    .move_from  (move_from),
    .move_to    (move_to),
    .move_done  (move_done),
    .move_err   (move_err),
    .captured   (captured),
    .board_flat (board_flat)
  );

  typedef struct {
    bit           is_err;
    logic [4:0]   cap;
    logic [319:0] board;
  } exp_t;

  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         acc_cnt = 0;
  logic [4:0] model [64];
  exp_t       sb [$];
  exp_t       mon_e;
  logic [319:0] start_flat;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [319:0] model_flat();
    logic [319:0] f;
    for (int i = 0; i < 64; i++) f[i*5 +: 5] = model[i];
    return f;
  endfunction

  task automatic model_reset();
    logic [2:0] bk [8];
    bk = '{3'd4, 3'd2, 3'd3, 3'd5, 3'd6, 3'd3, 3'd2, 3'd4};
    for (int i = 0; i < 64; i++) model[i] = 5'b0;
    for (int c = 0; c < 8; c++) begin
      model[c]      = {1'b1, bk[c], 1'b0};
      model[8 + c]  = 5'b10010;
      model[48 + c] = 5'b00010;
      model[56 + c] = {1'b0, bk[c], 1'b0};
    end
  endtask

  task automatic predict(input logic [5:0] f, input logic [5:0] t);
    exp_t       e;
    logic [4:0] p, np;
    p = model[f];
    e.is_err = (p == 5'b0) || (f == t);
    e.cap    = 5'b0;
    if (!e.is_err) begin
      e.cap = model[t];
      np = {p[4:1], 1'b1};
      if (p[3:1] == 3'd1 && ((!p[4] && t < 8) || (p[4] && t >= 56))) np[3:1] = 3'd5;
      model[t] = np;
      model[f] = 5'b0;
    end
    e.board = model_flat();
    sb.push_back(e);
  endtask

  always @(posedge clk) if (move_valid && move_ready) acc_cnt++;

  always @(negedge clk) begin
    if (!reset && (move_done || move_err)) begin
      if (move_done) done_cnt++;
      if (sb.size() == 0) chk("unexpected_pulse", {move_done, move_err}, 2'b00);
      else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {move_done, move_err}, mon_e.is_err ? 2'b01 : 2'b10);
        if (!mon_e.is_err) chk("captured", captured, mon_e.cap);
        chk("board_after", board_flat, mon_e.board);
      end
    end
  end

  task automatic send(input logic [5:0] f, input logic [5:0] t);
    int n = 0;
    @(negedge clk);
    move_from = f; move_to = t; move_valid = 1'b1;
    while (!move_ready && n < 200) begin @(negedge clk); n++; end
    chk("ready_timeout", n < 200, 1'b1);
    @(posedge clk);
    predict(f, t);
    @(negedge clk);
    move_valid = 1'b0;
  endtask

  task automatic vblank();
    @(negedge clk); vsync = 1'b0;
    repeat (8) @(negedge clk);
    vsync = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0, a0, n;
    model_reset();
    start_flat = model_flat();

    // 1: reset values
    repeat (3) @(negedge clk);
    chk("rst_done", move_done, 1'b0);
    chk("rst_err", move_err, 1'b0);
    chk("rst_captured", captured, 5'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_sq0", board_flat[0 +: 5], 5'b11000);
    chk("rst_sq60", board_flat[60*5 +: 5], 5'b01100);
    chk("rst_sq8", board_flat[8*5 +: 5], 5'b10010);
    chk("rst_sq30", board_flat[30*5 +: 5], 5'b00000);
    chk("rst_board", board_flat, start_flat);
    chk("rst_ready", move_ready, 1'b1);

    // 2: commit waits for vblank
    send(6'd52, 6'd36);
    repeat (100) @(negedge clk);
    chk("t2_no_done", done_cnt, 0);
    chk("t2_sq36_held", board_flat[36*5 +: 5], 5'b0);
    chk("t2_busy", move_ready, 1'b0);
    vsync = 1'b0;
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!move_done && k < 20);
    chk("t2_vb_latency", k, SS + 2);
    chk("t2_sq36", board_flat[36*5 +: 5], 5'b00011);
    chk("t2_sq52", board_flat[52*5 +: 5], 5'b0);
    chk("t2_captured", captured, 5'b0);
    repeat (4) @(negedge clk);
    vsync = 1'b1;
    drain();

    // 3: error latency, empty source then from==to
    send(6'd27, 6'd20);
    @(posedge clk); #1 chk("t3a_err_t1", move_err, 1'b0);
    @(posedge clk); #1 chk("t3a_err_t2", move_err, 1'b1);
    @(posedge clk); #1 chk("t3a_err_t3", move_err, 1'b0);
    chk("t3a_ready_t3", move_ready, 1'b1);
    send(6'd12, 6'd12);
    @(posedge clk); #1 chk("t3b_err_t1", move_err, 1'b0);
    @(posedge clk); #1 chk("t3b_err_t2", move_err, 1'b1);
    @(posedge clk); #1 chk("t3b_ready_t3", move_ready, 1'b1);
    drain();

    // 4: capture with promotion
    send(6'd49, 6'd9);  vblank(); drain();
    send(6'd9, 6'd0);   vblank(); drain();
    chk("t4_sq0_queen", board_flat[0 +: 5], 5'b01011);
    chk("t4_captured", captured, 5'b11000);
    chk("t4_sq9", board_flat[9*5 +: 5], 5'b0);

    // 5: new_game while waiting for vblank
    send(6'd50, 6'd34);
    repeat (5) @(negedge clk);
    new_game = 1'b1;
    void'(sb.pop_back());
    model_reset();
    #1 chk("t5_ready_low", move_ready, 1'b0);
    @(negedge clk); new_game = 1'b0;
    d0 = done_cnt;
    vblank();
    repeat (10) @(negedge clk);
    chk("t5_no_done", done_cnt, d0);
    chk("t5_board", board_flat, start_flat);
    chk("t5_ready", move_ready, 1'b1);

    // 6: new_game on the commit edge
    send(6'd51, 6'd35);
    repeat (3) @(negedge clk);
    vsync = 1'b0;
    repeat (SS + 1) @(posedge clk);
    @(negedge clk);
    new_game = 1'b1;
    void'(sb.pop_back());
    model_reset();
    @(negedge clk); new_game = 1'b0;
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_no_done", done_cnt, d0);
    chk("t6_board", board_flat, start_flat);

    // 7: valid held through the whole transaction -> one accept
    @(negedge clk);
    a0 = acc_cnt;
    move_from = 6'd52; move_to = 6'd36; move_valid = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 50) begin @(negedge clk); n++; end
    predict(6'd52, 6'd36);
    vsync = 1'b0;
    n = 0;
    while (!move_done && n < 100) begin @(negedge clk); n++; end
    move_valid = 1'b0;
    chk("t7_one_accept", acc_cnt - a0, 1);
    repeat (3) @(negedge clk);
    vsync = 1'b1;
    drain();
    chk("t7_sq36", board_flat[36*5 +: 5], 5'b00011);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
